// File: rtl/sirius_axi_pkg.sv
// Shared types and constants for the multi-port AXI bridge.
package sirius_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_W,
      ST_B
   } state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      clog2 = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) clog2 = i + 1;
      end
   endfunction

endpackage

// File: rtl/axi_multi_port_bridge_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module rr_arbiter
   import sirius_axi_pkg::*;
#(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = (N > 1) ? clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] grant_idx_c
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic          found;

   // First requester at or after the pointer, wrapping modulo N.
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      found       = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found          = 1'b1;
            grant_idx_c    = cand;
            grant_c[cand]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (grant_idx_c == IW'(N - 1)) ? '0 : grant_idx_c + 1'b1;
      end
   end

endmodule

// File: rtl/axi_multi_port_bridge.sv
// Arbitrates NPORT simple request ports onto one AXI master, one transaction in flight.
module axi_multi_port_bridge
   import sirius_axi_pkg::*;
#(
   parameter int unsigned NPORT     = 3,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned ID_W      = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [NPORT-1:0]    p_req,
   input  logic [NPORT-1:0]    p_we,
   input  logic [NPORT-1:0]    p_line,
   input  logic [NPORT*32-1:0] p_addr,
   input  logic [NPORT*4-1:0]  p_wstrb,
   input  logic [NPORT*32-1:0] p_wdata,
   output logic [31:0]         p_rdata,
   output logic [NPORT-1:0]    p_rvalid,
   output logic [NPORT-1:0]    p_done,
   output logic [NPORT-1:0]    p_err,
   output logic [ID_W-1:0]     arid,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arlock,
   output logic [3:0]          arcache,
   output logic [2:0]          arprot,
   output logic                arvalid,
   input  logic                arready,
   input  logic [ID_W-1:0]     rid,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   output logic [ID_W-1:0]     awid,
   output logic [31:0]         awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awlock,
   output logic [3:0]          awcache,
   output logic [2:0]          awprot,
   output logic                awvalid,
   input  logic                awready,
   output logic [ID_W-1:0]     wid,
   output logic [31:0]         wdata,
   output logic [3:0]          wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [ID_W-1:0]     bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam int unsigned IW = (NPORT > 1) ? clog2(NPORT) : 1;
   localparam int unsigned CW = clog2(BURST_LEN) + 1;

   state_e           state, state_nxt;
   logic [IW-1:0]    win;
   logic             line_q;
   logic             err_q;
   logic [CW-1:0]    beat_cnt;

   logic [NPORT-1:0] req_eff;
   logic [NPORT-1:0] grant;
   logic [IW-1:0]    gidx;
   logic             grant_any;
   logic [31:0]      addr_sel;
   logic [CW-1:0]    last_idx;
   logic             beat_err;

   assign arsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 1'b0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign awlen   = 8'd0;
   assign awsize  = AXI_SIZE_4B;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = 1'b0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign wlast   = 1'b1;

   // A port's request is still high in its own p_done cycle; hide it so it is not re-granted stale.
   assign req_eff   = p_req & ~p_done;
   assign grant_any = |grant;

   rr_arbiter #(.N(NPORT)) u_arb (
      .clk         (aclk),
      .rst_n       (aresetn),
      .req         (req_eff),
      .advance     (state == ST_IDLE),
      .grant_c     (grant),
      .grant_idx_c (gidx)
   );

   always_comb begin
      state_nxt = state;
      addr_sel  = p_addr[32*gidx +: 32];
      last_idx  = line_q ? CW'(BURST_LEN - 1) : '0;
      // Early rlast, missing rlast on the final beat, bad resp or foreign id all mark the burst bad.
      beat_err  = (rresp != AXI_RESP_OKAY) || (rid != ID_W'(win)) ||
                  (rlast && (beat_cnt != last_idx)) ||
                  (!rlast && (beat_cnt >= last_idx));
      case (state)
         ST_IDLE: if (grant_any) state_nxt = p_we[gidx] ? ST_W : ST_AR;
         ST_AR:   if (arvalid && arready) state_nxt = ST_R;
         ST_R:    if (rvalid && rready && rlast) state_nxt = ST_IDLE;
         ST_W:    if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = ST_B;
         ST_B:    if (bvalid && bready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         win      <= '0;
         line_q   <= 1'b0;
         err_q    <= 1'b0;
         beat_cnt <= '0;
         p_rdata  <= '0;
         p_rvalid <= '0;
         p_done   <= '0;
         p_err    <= '0;
         arid     <= '0;
         araddr   <= '0;
         arlen    <= '0;
         arvalid  <= 1'b0;
         rready   <= 1'b0;
         awid     <= '0;
         awaddr   <= '0;
         awvalid  <= 1'b0;
         wid      <= '0;
         wdata    <= '0;
         wstrb    <= '0;
         wvalid   <= 1'b0;
         bready   <= 1'b0;
      end else begin
         state    <= state_nxt;
         arvalid  <= (state_nxt == ST_AR);
         rready   <= (state_nxt == ST_R);
         bready   <= (state_nxt == ST_B);
         p_rvalid <= '0;
         p_done   <= '0;
         p_err    <= '0;

         // Capture the winner's request; later port-side changes are ignored.
         if (state == ST_IDLE && grant_any) begin
            win      <= gidx;
            line_q   <= p_line[gidx];
            err_q    <= 1'b0;
            beat_cnt <= '0;
            arid     <= ID_W'(gidx);
            awid     <= ID_W'(gidx);
            wid      <= ID_W'(gidx);
            araddr   <= p_line[gidx] ? (addr_sel & ~32'(BURST_LEN*4 - 1)) : addr_sel;
            arlen    <= p_line[gidx] ? 8'(BURST_LEN - 1) : 8'd0;
            awaddr   <= addr_sel;
            wdata    <= p_wdata[32*gidx +: 32];
            wstrb    <= p_wstrb[4*gidx +: 4];
         end

         if (state == ST_IDLE && state_nxt == ST_W) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
         end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
         end

         if (state == ST_R && rvalid && rready) begin
            p_rdata       <= rdata;
            p_rvalid[win] <= 1'b1;
            err_q         <= err_q | beat_err;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (rlast) begin
               p_done[win] <= 1'b1;
               p_err[win]  <= err_q | beat_err;
            end
         end

         if (state == ST_B && bvalid && bready) begin
            p_done[win] <= 1'b1;
            p_err[win]  <= (bresp != AXI_RESP_OKAY) || (bid != ID_W'(win));
         end
      end
   end

endmodule

// File: tb/tb_axi_multi_port_bridge.sv
// Directed bench for axi_multi_port_bridge: vector table plus reset/round-robin sequences.
module tb_axi_multi_port_bridge;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [2:0]  p_req, p_we, p_line;
   logic [95:0] p_addr, p_wdata;
   logic [11:0] p_wstrb;
   logic [31:0] p_rdata;
   logic [2:0]  p_rvalid, p_done, p_err;
   logic [3:0]  arid, rid, awid, wid, bid;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arlock, arvalid, arready, rlast, rvalid, rready;
   logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int total = 0;
   int bad   = 0;

   axi_multi_port_bridge #(.NPORT(3), .BURST_LEN(8), .ID_W(4)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .p_req(p_req), .p_we(p_we), .p_line(p_line), .p_addr(p_addr),
      .p_wstrb(p_wstrb), .p_wdata(p_wdata), .p_rdata(p_rdata),
      .p_rvalid(p_rvalid), .p_done(p_done), .p_err(p_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int          port;
      bit          we;
      bit          line;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
      int          beats;
      logic [1:0]  resp;
      int          aw_dly;
      logic [31:0] exp_addr;
      logic [7:0]  exp_len;
      bit          exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] oh(input int p);
      oh = 3'(1 << p);
   endfunction

   function automatic logic [31:0] pat(input int p, input int b);
      pat = 32'hD000_0000 | 32'(b << 8) | 32'(p);
   endfunction

   // Wait (bounded) for arvalid or awvalid; lat counts negedges from the call.
   task automatic wait_valid(input bit is_wr, output int lat);
      lat = 0;
      while (!(is_wr ? awvalid : arvalid) && lat < 16) begin
         @(negedge aclk);
         lat++;
      end
      chk(is_wr ? "aw_seen" : "ar_seen", 64'(is_wr ? awvalid : arvalid), 64'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int  lat;
      int  wbeats;
      bit  aw_ok, w_ok;
      @(negedge aclk);
      p_req[v.port]          = 1'b1;
      p_we[v.port]           = v.we;
      p_line[v.port]         = v.line;
      p_addr[32*v.port +: 32]  = v.addr;
      p_wdata[32*v.port +: 32] = v.data;
      p_wstrb[4*v.port +: 4]   = v.strb;
      wait_valid(v.we, lat);
      chk("req_to_valid_lat", 64'(lat), 64'd1);
      if (!v.we) begin
         chk("araddr", 64'(araddr), 64'(v.exp_addr));
         chk("arlen_arid", {arlen, arid}, {8'(v.exp_len), 4'(v.port)});
         chk("ar_attr", {arsize, arburst, arlock, arcache, arprot}, {3'b010, 2'b01, 1'b0, 4'd0, 3'd0});
         arready = 1'b1;
         @(negedge aclk);
         arready = 1'b0;
         chk("rready_arvalid", {rready, arvalid}, {1'b1, 1'b0});
         for (int b = 0; b < v.beats; b++) begin
            rvalid = 1'b1; rdata = pat(v.port, b); rid = 4'(v.port);
            rresp = v.resp; rlast = (b == v.beats - 1);
            @(negedge aclk);
            chk($sformatf("rd_beat%0d", b), {p_rvalid, p_rdata}, {oh(v.port), pat(v.port, b)});
            if (b == v.beats - 1)
               chk("rd_done_err", {p_done, p_err}, {oh(v.port), v.exp_err ? oh(v.port) : 3'b0});
            else
               chk("rd_no_done", 64'(p_done), 64'd0);
         end
         rvalid = 1'b0; rlast = 1'b0;
      end else begin
         chk("wvalid_with_aw", 64'(wvalid), 64'd1);
         chk("aw_fields", {awaddr, awid, wid}, {v.exp_addr, 4'(v.port), 4'(v.port)});
         chk("w_fields", {wdata, wstrb}, {v.data, v.strb});
         chk("aw_attr", {awlen, awsize, awburst, wlast}, {8'd0, 3'b010, 2'b01, 1'b1});
         wbeats = 0; aw_ok = 1'b0; w_ok = 1'b0;
         for (int c = 0; c < 20 && !(aw_ok && w_ok); c++) begin
            wready  = 1'b1;
            awready = (c >= v.aw_dly);
            if (wvalid) begin wbeats++; w_ok = 1'b1; end
            if (awvalid && awready) aw_ok = 1'b1;
            @(negedge aclk);
         end
         awready = 1'b0; wready = 1'b0;
         chk("w_beat_count", 64'(wbeats), 64'd1);
         chk("aw_accepted", 64'(aw_ok), 64'd1);
         chk("bready_state", {bready, awvalid, wvalid}, {1'b1, 1'b0, 1'b0});
         bvalid = 1'b1; bresp = v.resp; bid = 4'(v.port);
         @(negedge aclk);
         bvalid = 1'b0;
         chk("wr_done_err", {p_done, p_err}, {oh(v.port), v.exp_err ? oh(v.port) : 3'b0});
      end
      p_req[v.port] = 1'b0;
      @(negedge aclk);
      chk("post_idle", {p_done, p_rvalid, arvalid, awvalid}, {3'b0, 3'b0, 1'b0, 1'b0});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [3:0] id;
      int exp_order [4];
      //            port we line addr           strb    data          beats resp  dly exp_addr       len  err
      vecs[0] = '{1, 0, 1, 32'h1FC0_0014, 4'h0, 32'h0,          8, 2'b00, 0, 32'h1FC0_0000, 8'd7, 0};
      vecs[1] = '{0, 0, 0, 32'h1000_0006, 4'h0, 32'h0,          1, 2'b10, 0, 32'h1000_0006, 8'd0, 1};
      vecs[2] = '{2, 0, 1, 32'h8000_003C, 4'h0, 32'h0,          4, 2'b00, 0, 32'h8000_0020, 8'd7, 1};
      vecs[3] = '{0, 0, 1, 32'h0000_0100, 4'h0, 32'h0,          9, 2'b00, 0, 32'h0000_0100, 8'd7, 1};
      vecs[4] = '{2, 1, 0, 32'h2000_0008, 4'b0011, 32'hCAFE_F00D, 1, 2'b00, 3, 32'h2000_0008, 8'd0, 0};
      vecs[5] = '{1, 1, 0, 32'h3000_0000, 4'b1111, 32'h1234_5678, 1, 2'b11, 0, 32'h3000_0000, 8'd0, 1};
      vecs[6] = '{2, 0, 0, 32'h4000_0010, 4'h0, 32'h0,          1, 2'b00, 0, 32'h4000_0010, 8'd0, 0};
      exp_order = '{0, 1, 2, 0};

      aresetn = 1'b0;
      p_req = 3'b111; p_we = '0; p_line = '0; p_addr = '0; p_wdata = '0; p_wstrb = '0;
      arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

      // Requests held during reset must not leak onto the bus.
      repeat (3) begin
         @(negedge aclk);
         chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
         chk("rst_pulses", {p_rvalid, p_done, p_err, p_rdata}, 41'b0);
      end
      aresetn = 1'b1;

      // All three ports hammer single reads: grants rotate 0,1,2,0.
      for (int t = 0; t < 4; t++) begin
         wait_valid(1'b0, lat);
         chk($sformatf("rr_grant%0d", t), 64'(arid), 64'(exp_order[t]));
         id = arid;
         if (t == 3) p_req = 3'b000;
         arready = 1'b1;
         @(negedge aclk);
         arready = 1'b0;
         rvalid = 1'b1; rlast = 1'b1; rid = id; rdata = pat(int'(id), 9); rresp = 2'b00;
         @(negedge aclk);
         rvalid = 1'b0; rlast = 1'b0;
         chk($sformatf("rr_done%0d", t), {p_done, p_rvalid, p_err, p_rdata},
             {oh(int'(id)), oh(int'(id)), 3'b0, pat(int'(id), 9)});
      end
      @(negedge aclk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset asserted while beat 3 of a line read is on the bus.
      @(negedge aclk);
      p_req[1] = 1'b1; p_we[1] = 1'b0; p_line[1] = 1'b1; p_addr[63:32] = 32'h0000_0040;
      wait_valid(1'b0, lat);
      arready = 1'b1;
      @(negedge aclk);
      arready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         rvalid = 1'b1; rlast = 1'b0; rid = 4'd1; rdata = pat(1, b); rresp = 2'b00;
         if (b < 2) @(negedge aclk);
      end
      chk("pre_rst_rvalid", 64'(p_rvalid), 64'(oh(1)));
      #1 aresetn = 1'b0;
      #1;
      chk("mid_rst_clear", {rready, arvalid, p_rvalid, p_done, p_err, p_rdata}, 43'b0);
      rvalid = 1'b0; p_req = 3'b000;
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (4) begin
         @(negedge aclk);
         chk("post_rst_quiet", {p_done, p_rvalid, arvalid, awvalid, rready}, 9'b0);
      end

      // A fresh transaction after the aborted one completes normally.
      run_vec(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
